// File: rtl/lsu.sv
// lsu: load/store unit on the execute stage memory-operation port.
// One op outstanding; runs a bus req/rsp and returns extended load data.
module lsu #(
    parameter int XLEN          = 64,
    parameter int MEMOP_LEN     = 4,
    parameter int REG_ADDRWIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [MEMOP_LEN-1:0]     mem_op_i,
    input  logic [XLEN-1:0]          addr_i,
    input  logic [XLEN-1:0]          wdata_i,
    input  logic [REG_ADDRWIDTH-1:0] rd_idx_i,
    output logic                     done_o,
    output logic [XLEN-1:0]          rdata_o,
    output logic [REG_ADDRWIDTH-1:0] rd_idx_o,
    output logic                     misalign_o,
    output logic                     req_valid_o,
    input  logic                     req_ready_i,
    output logic [XLEN-1:0]          req_addr_o,
    output logic                     req_wen_o,
    output logic [XLEN-1:0]          req_wdata_o,
    output logic [7:0]               req_wmask_o,
    input  logic                     rsp_valid_i,
    input  logic [XLEN-1:0]          rsp_rdata_i,
    output logic                     rsp_ready_o
);
    localparam logic [MEMOP_LEN-1:0] OP_LB  = MEMOP_LEN'(1);
    localparam logic [MEMOP_LEN-1:0] OP_LBU = MEMOP_LEN'(2);
    localparam logic [MEMOP_LEN-1:0] OP_LH  = MEMOP_LEN'(3);
    localparam logic [MEMOP_LEN-1:0] OP_LHU = MEMOP_LEN'(4);
    localparam logic [MEMOP_LEN-1:0] OP_LW  = MEMOP_LEN'(5);
    localparam logic [MEMOP_LEN-1:0] OP_LWU = MEMOP_LEN'(6);
    localparam logic [MEMOP_LEN-1:0] OP_LD  = MEMOP_LEN'(7);
    localparam logic [MEMOP_LEN-1:0] OP_SB  = MEMOP_LEN'(8);
    localparam logic [MEMOP_LEN-1:0] OP_SH  = MEMOP_LEN'(9);
    localparam logic [MEMOP_LEN-1:0] OP_SW  = MEMOP_LEN'(10);
    localparam logic [MEMOP_LEN-1:0] OP_SD  = MEMOP_LEN'(11);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP, S_FIN} state_t;

    state_t                   state_q;
    logic [MEMOP_LEN-1:0]     op_q;
    logic [2:0]               off_q;
    logic                     ready_q, done_q, mis_q;
    logic                     req_valid_q, rsp_ready_q, req_wen_q;
    logic [XLEN-1:0]          rdata_q, req_addr_q, req_wdata_q;
    logic [7:0]               req_wmask_q;
    logic [REG_ADDRWIDTH-1:0] rd_idx_q;

    logic [1:0]      size_c;
    logic            is_ld_c, is_st_c, mis_c;
    logic [2:0]      off_c;
    logic [7:0]      req_wmask_d;
    logic [XLEN-1:0] req_wdata_d, lane_c, rdata_d;

    assign off_c       = addr_i[2:0];
    assign req_wdata_d = wdata_i << {off_c, 3'b000};

    // Decode the offered op: access size, direction, alignment, byte mask
    always_comb begin
        size_c      = 2'd0;
        is_ld_c     = 1'b0;
        is_st_c     = 1'b0;
        mis_c       = 1'b0;
        req_wmask_d = 8'h00;
        unique case (mem_op_i)
            OP_LB, OP_LBU: begin is_ld_c = 1'b1; size_c = 2'd0; end
            OP_LH, OP_LHU: begin is_ld_c = 1'b1; size_c = 2'd1; end
            OP_LW, OP_LWU: begin is_ld_c = 1'b1; size_c = 2'd2; end
            OP_LD:         begin is_ld_c = 1'b1; size_c = 2'd3; end
            OP_SB:         begin is_st_c = 1'b1; size_c = 2'd0; end
            OP_SH:         begin is_st_c = 1'b1; size_c = 2'd1; end
            OP_SW:         begin is_st_c = 1'b1; size_c = 2'd2; end
            OP_SD:         begin is_st_c = 1'b1; size_c = 2'd3; end
            default:       ;
        endcase
        unique case (size_c)
            2'd0: begin mis_c = 1'b0;          req_wmask_d = 8'h01; end
            2'd1: begin mis_c = off_c[0];      req_wmask_d = 8'h03; end
            2'd2: begin mis_c = |off_c[1:0];   req_wmask_d = 8'h0F; end
            2'd3: begin mis_c = |off_c;        req_wmask_d = 8'hFF; end
        endcase
        mis_c       = mis_c & (is_ld_c | is_st_c);
        req_wmask_d = is_st_c ? (req_wmask_d << off_c) : 8'h00;
    end

    assign lane_c = rsp_rdata_i >> {off_q, 3'b000};

    // Extract and extend the addressed lane for the latched load op
    always_comb begin
        rdata_d = '0;
        unique case (op_q)
            OP_LB:   rdata_d = {{(XLEN-8){lane_c[7]}}, lane_c[7:0]};
            OP_LBU:  rdata_d = {{(XLEN-8){1'b0}}, lane_c[7:0]};
            OP_LH:   rdata_d = {{(XLEN-16){lane_c[15]}}, lane_c[15:0]};
            OP_LHU:  rdata_d = {{(XLEN-16){1'b0}}, lane_c[15:0]};
            OP_LW:   rdata_d = {{(XLEN-32){lane_c[31]}}, lane_c[31:0]};
            OP_LWU:  rdata_d = {{(XLEN-32){1'b0}}, lane_c[31:0]};
            OP_LD:   rdata_d = lane_c;
            default: rdata_d = '0;
        endcase
    end

    // Transaction FSM with all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            off_q       <= '0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            mis_q       <= 1'b0;
            req_valid_q <= 1'b0;
            rsp_ready_q <= 1'b0;
            req_wen_q   <= 1'b0;
            rdata_q     <= '0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wmask_q <= '0;
            rd_idx_q    <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: if (valid_i) begin
                    op_q        <= mem_op_i;
                    off_q       <= off_c;
                    ready_q     <= 1'b0;
                    mis_q       <= mis_c;
                    rdata_q     <= '0;
                    req_wen_q   <= is_st_c;
                    req_addr_q  <= {addr_i[XLEN-1:3], 3'b000};
                    req_wdata_q <= req_wdata_d;
                    req_wmask_q <= req_wmask_d;
                    rd_idx_q    <= rd_idx_i;
                    if ((is_ld_c | is_st_c) & ~mis_c) begin
                        state_q     <= S_REQ;
                        req_valid_q <= 1'b1;
                    end else begin
                        state_q <= S_FIN;
                        done_q  <= 1'b1;
                    end
                end
                S_REQ: if (req_ready_i) begin
                    state_q     <= S_RSP;
                    req_valid_q <= 1'b0;
                    rsp_ready_q <= 1'b1;
                end
                S_RSP: if (rsp_valid_i) begin
                    state_q     <= S_FIN;
                    rsp_ready_q <= 1'b0;
                    rdata_q     <= rdata_d;
                    done_q      <= 1'b1;
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o     = ready_q;
    assign done_o      = done_q;
    assign rdata_o     = rdata_q;
    assign rd_idx_o    = rd_idx_q;
    assign misalign_o  = mis_q;
    assign req_valid_o = req_valid_q;
    assign req_addr_o  = req_addr_q;
    assign req_wen_o   = req_wen_q;
    assign req_wdata_o = req_wdata_q;
    assign req_wmask_o = req_wmask_q;
    assign rsp_ready_o = rsp_ready_q;
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: vector table, corner sequences and random ops for lsu,
// checked against an arithmetic reference model.
module tb_lsu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [3:0]  mem_op_i = '0;
    logic [63:0] addr_i = '0;
    logic [63:0] wdata_i = '0;
    logic [4:0]  rd_idx_i = '0;
    logic        done_o;
    logic [63:0] rdata_o;
    logic [4:0]  rd_idx_o;
    logic        misalign_o;
    logic        req_valid_o;
    logic        req_ready_i = 1'b0;
    logic [63:0] req_addr_o;
    logic        req_wen_o;
    logic [63:0] req_wdata_o;
    logic [7:0]  req_wmask_o;
    logic        rsp_valid_i = 1'b0;
    logic [63:0] rsp_rdata_i = '0;
    logic        rsp_ready_o;

    int nchk = 0;
    int nerr = 0;

    lsu #(.XLEN(64), .MEMOP_LEN(4), .REG_ADDRWIDTH(5)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
        .mem_op_i(mem_op_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .rd_idx_i(rd_idx_i), .done_o(done_o), .rdata_o(rdata_o),
        .rd_idx_o(rd_idx_o), .misalign_o(misalign_o),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
        .req_addr_o(req_addr_o), .req_wen_o(req_wen_o),
        .req_wdata_o(req_wdata_o), .req_wmask_o(req_wmask_o),
        .rsp_valid_i(rsp_valid_i), .rsp_rdata_i(rsp_rdata_i),
        .rsp_ready_o(rsp_ready_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          bus;
        bit          mis;
        logic [63:0] req_addr;
        bit          wen;
        logic [7:0]  wmask;
        logic [63:0] wdata;
        logic [63:0] rdata;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rsp;
        logic [4:0]  rd;
        int          nreq;
        int          nrsp;
        exp_t        e;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t mke(bit bus, bit mis, logic [63:0] ra, bit wen,
                                 logic [7:0] wm, logic [63:0] wd, logic [63:0] rv);
        exp_t e;
        e.bus = bus; e.mis = mis; e.req_addr = ra; e.wen = wen;
        e.wmask = wm; e.wdata = wd; e.rdata = rv;
        return e;
    endfunction

    function automatic vec_t mkv(logic [3:0] op, logic [63:0] a, logic [63:0] wd,
                                 logic [63:0] rs, logic [4:0] rd, int nq, int ns, exp_t e);
        vec_t v;
        v.op = op; v.addr = a; v.wdata = wd; v.rsp = rs; v.rd = rd;
        v.nreq = nq; v.nrsp = ns; v.e = e;
        return v;
    endfunction

    // Reference: size in bytes, byte offset, modular arithmetic for extension
    function automatic exp_t model(logic [3:0] op, logic [63:0] a,
                                   logic [63:0] wd, logic [63:0] rs);
        exp_t e;
        int sz, off;
        bit ld, st, sg;
        logic [127:0] v;
        e = mke(0, 0, 64'h0, 0, 8'h0, 64'h0, 64'h0);
        sz = 0; ld = 0; st = 0; sg = 0;
        case (op)
            4'd1:  begin ld = 1; sz = 1; sg = 1; end
            4'd2:  begin ld = 1; sz = 1; end
            4'd3:  begin ld = 1; sz = 2; sg = 1; end
            4'd4:  begin ld = 1; sz = 2; end
            4'd5:  begin ld = 1; sz = 4; sg = 1; end
            4'd6:  begin ld = 1; sz = 4; end
            4'd7:  begin ld = 1; sz = 8; end
            4'd8:  begin st = 1; sz = 1; end
            4'd9:  begin st = 1; sz = 2; end
            4'd10: begin st = 1; sz = 4; end
            4'd11: begin st = 1; sz = 8; end
            default: ;
        endcase
        off = int'(a % 64'd8);
        if (ld || st) e.mis = (off % sz) != 0;
        e.bus = (ld || st) && !e.mis;
        e.req_addr = a - 64'(off);
        if (e.bus && st) begin
            e.wen   = 1;
            e.wmask = 8'(((1 << sz) - 1) << off);
            e.wdata = wd * (64'd1 << (8 * off));
        end
        if (e.bus && ld) begin
            v = 128'(rs / (64'd1 << (8 * off))) % (128'd1 << (8 * sz));
            if (sg && v >= (128'd1 << (8 * sz - 1)))
                v = v + ((128'd1 << 64) - (128'd1 << (8 * sz)));
            e.rdata = v[63:0];
        end
        return e;
    endfunction

    task automatic run_op(input string nm, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] wd, input logic [63:0] rs, input logic [4:0] rd,
                          input int nq, input int ns, input exp_t e);
        bit early;
        early = 0;
        @(negedge clk);
        chk({nm, " ready_idle"}, 64'(ready_o), 64'd1);
        valid_i = 1; mem_op_i = op; addr_i = a; wdata_i = wd; rd_idx_i = rd;
        @(negedge clk);
        valid_i = e.bus; mem_op_i = 4'd7; rd_idx_i = ~rd; addr_i = ~a;
        if (e.bus) begin
            for (int k = 0; k <= nq; k++) begin
                chk({nm, " req_valid"}, 64'(req_valid_o), 64'd1);
                chk({nm, " req_addr"}, req_addr_o, e.req_addr);
                chk({nm, " req_wen"}, 64'(req_wen_o), 64'(e.wen));
                chk({nm, " req_wmask"}, 64'(req_wmask_o), 64'(e.wmask));
                if (e.wen) chk({nm, " req_wdata"}, req_wdata_o, e.wdata);
                chk({nm, " ready_busy"}, 64'(ready_o), 64'd0);
                if (done_o) early = 1;
                rsp_valid_i = 1; rsp_rdata_i = ~rs;
                req_ready_i = (k == nq);
                @(negedge clk);
            end
            req_ready_i = 0;
            for (int k = 0; k <= ns; k++) begin
                chk({nm, " rsp_ready"}, 64'(rsp_ready_o), 64'd1);
                chk({nm, " req_valid_off"}, 64'(req_valid_o), 64'd0);
                chk({nm, " ready_busy"}, 64'(ready_o), 64'd0);
                if (done_o) early = 1;
                rsp_valid_i = (k == ns);
                rsp_rdata_i = (k == ns) ? rs : ~rs;
                @(negedge clk);
            end
            rsp_valid_i = 0;
            valid_i = 0;
        end else begin
            chk({nm, " no_req"}, 64'(req_valid_o), 64'd0);
        end
        chk({nm, " early_done"}, 64'(early), 64'd0);
        chk({nm, " done"}, 64'(done_o), 64'd1);
        chk({nm, " ready_fin"}, 64'(ready_o), 64'd0);
        chk({nm, " rdata"}, rdata_o, e.rdata);
        chk({nm, " rd_idx"}, 64'(rd_idx_o), 64'(rd));
        chk({nm, " misalign"}, 64'(misalign_o), 64'(e.mis));
        @(negedge clk);
        chk({nm, " done_pulse"}, 64'(done_o), 64'd0);
        chk({nm, " ready_back"}, 64'(ready_o), 64'd1);
        for (int k = 0; k < 10 && !ready_o; k++) @(negedge clk);
    endtask

    initial begin
        int acc[$];
        int dn[$];
        logic [3:0]  rop;
        logic [63:0] ra, rw, rr;
        exp_t        re;

        vecs[0]  = mkv(4'd1, 64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000, 5'd1, 0, 0,
                       mke(1, 0, 64'h8000_0000, 0, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80));
        vecs[1]  = mkv(4'd2, 64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000, 5'd2, 0, 0,
                       mke(1, 0, 64'h8000_0000, 0, 8'h00, 64'h0, 64'h80));
        vecs[2]  = mkv(4'd10, 64'h8000_0004, 64'h1234_5678, 64'hFFFF, 5'd3, 0, 0,
                       mke(1, 0, 64'h8000_0000, 1, 8'hF0, 64'h1234_5678_0000_0000, 64'h0));
        vecs[3]  = mkv(4'd7, 64'h8000_0002, 64'h0, 64'h0, 5'd4, 0, 0,
                       mke(0, 1, 64'h0, 0, 8'h00, 64'h0, 64'h0));
        vecs[4]  = mkv(4'd3, 64'h8000_0006, 64'h0, 64'hABCD_0000_0000_0000, 5'd5, 3, 2,
                       mke(1, 0, 64'h8000_0000, 0, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_ABCD));
        vecs[5]  = mkv(4'd6, 64'h8000_0004, 64'h0, 64'h8765_4321_0000_0000, 5'd6, 1, 0,
                       mke(1, 0, 64'h8000_0000, 0, 8'h00, 64'h0, 64'h8765_4321));
        vecs[6]  = mkv(4'd5, 64'h8000_0004, 64'h0, 64'h8765_4321_0000_0000, 5'd7, 0, 1,
                       mke(1, 0, 64'h8000_0000, 0, 8'h00, 64'h0, 64'hFFFF_FFFF_8765_4321));
        vecs[7]  = mkv(4'd8, 64'h8000_0007, 64'hAB, 64'h0, 5'd8, 0, 0,
                       mke(1, 0, 64'h8000_0000, 1, 8'h80, 64'hAB00_0000_0000_0000, 64'h0));
        vecs[8]  = mkv(4'd9, 64'h0000_0001, 64'h55, 64'h0, 5'd9, 0, 0,
                       mke(0, 1, 64'h0, 0, 8'h00, 64'h0, 64'h0));
        vecs[9]  = mkv(4'd0, 64'h1000, 64'h0, 64'h0, 5'd10, 0, 0,
                       mke(0, 0, 64'h0, 0, 8'h00, 64'h0, 64'h0));
        vecs[10] = mkv(4'd13, 64'h1000, 64'h0, 64'h0, 5'd11, 0, 0,
                       mke(0, 0, 64'h0, 0, 8'h00, 64'h0, 64'h0));
        vecs[11] = mkv(4'd11, 64'h8, 64'h0123_4567_89AB_CDEF, 64'h0, 5'd12, 0, 0,
                       mke(1, 0, 64'h8, 1, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0));
        vecs[12] = mkv(4'd4, 64'h2, 64'h0, 64'h0000_0000_F00D_0000, 5'd13, 0, 0,
                       mke(1, 0, 64'h0, 0, 8'h00, 64'h0, 64'hF00D));

        repeat (2) @(negedge clk);
        chk("rst ready", 64'(ready_o), 64'd1);
        chk("rst req_valid", 64'(req_valid_o), 64'd0);
        chk("rst rsp_ready", 64'(rsp_ready_o), 64'd0);
        chk("rst done", 64'(done_o), 64'd0);
        chk("rst rdata", rdata_o, 64'd0);
        chk("rst rd_idx", 64'(rd_idx_o), 64'd0);
        chk("rst misalign", 64'(misalign_o), 64'd0);
        chk("rst req_addr", req_addr_o, 64'd0);
        chk("rst req_wen", 64'(req_wen_o), 64'd0);
        chk("rst req_wdata", req_wdata_o, 64'd0);
        chk("rst req_wmask", 64'(req_wmask_o), 64'd0);
        rst = 0;

        for (int i = 0; i < 13; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].wdata,
                   vecs[i].rsp, vecs[i].rd, vecs[i].nreq, vecs[i].nrsp, vecs[i].e);

        // Reset while waiting in RSP
        @(negedge clk);
        valid_i = 1; mem_op_i = 4'd5; addr_i = 64'h8000_0000; rd_idx_i = 5'd7;
        @(negedge clk);
        valid_i = 0; req_ready_i = 1;
        @(negedge clk);
        req_ready_i = 0;
        chk("rstrsp pre rsp_ready", 64'(rsp_ready_o), 64'd1);
        #1 rst = 1;
        #1;
        chk("rstrsp rsp_ready", 64'(rsp_ready_o), 64'd0);
        chk("rstrsp done", 64'(done_o), 64'd0);
        chk("rstrsp rdata", rdata_o, 64'd0);
        chk("rstrsp ready", 64'(ready_o), 64'd1);
        chk("rstrsp rd_idx", 64'(rd_idx_o), 64'd0);
        @(negedge clk);
        rst = 0;
        run_op("after_rst", 4'd5, 64'h8000_0000, 64'h0, 64'h1111_2222_8765_4321, 5'd9, 0, 0,
               mke(1, 0, 64'h8000_0000, 0, 8'h00, 64'h0, 64'hFFFF_FFFF_8765_4321));

        // Back-to-back LD, SD, NONE with valid held high and an eager bus
        req_ready_i = 1; rsp_valid_i = 1; rsp_rdata_i = 64'hDEAD_BEEF_CAFE_F00D;
        wdata_i = 64'h5A5A; rd_idx_i = 5'd3; addr_i = 64'h100;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            valid_i  = (c < 9);
            mem_op_i = (c <= 3) ? 4'd7 : (c <= 7) ? 4'd11 : 4'd0;
            if (ready_o && valid_i) acc.push_back(c);
            if (done_o) dn.push_back(c);
            if (c == 3) chk("b2b ld rdata", rdata_o, 64'hDEAD_BEEF_CAFE_F00D);
            if (c == 5) chk("b2b sd wmask", 64'(req_wmask_o), 64'hFF);
        end
        req_ready_i = 0; rsp_valid_i = 0; valid_i = 0;
        chk("b2b accepts", 64'(acc.size()), 64'd3);
        chk("b2b dones", 64'(dn.size()), 64'd3);
        if (acc.size() == 3) begin
            chk("b2b acc0", 64'(acc[0]), 64'd0);
            chk("b2b acc1", 64'(acc[1]), 64'd4);
            chk("b2b acc2", 64'(acc[2]), 64'd8);
        end
        if (dn.size() == 3) begin
            chk("b2b done0", 64'(dn[0]), 64'd3);
            chk("b2b done1", 64'(dn[1]), 64'd7);
            chk("b2b done2", 64'(dn[2]), 64'd9);
        end
        for (int k = 0; k < 10 && !ready_o; k++) @(negedge clk);

        // Random ops against the reference model
        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) ra[2:0] = 3'b000;
            rw  = {$urandom, $urandom};
            rr  = {$urandom, $urandom};
            re  = model(rop, ra, rw, rr);
            run_op($sformatf("rnd%0d op%0d", i, rop), rop, ra, rw, rr,
                   5'($urandom_range(0, 31)), $urandom_range(0, 2),
                   $urandom_range(0, 2), re);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit: the responder side of the execute stage's memory-operation output. It accepts one memory operation per handshake: the `mem_op`, the effective address (the execute result) and the store data (rs2). It runs a request/response transaction on the data-memory bus, then returns sign- or zero-extended load data with the destination register index to writeback. The execute/decode front end stalls on `ready_o` while a transaction is outstanding.

## Interface
- `XLEN`, 64: data/address width. The byte-lane logic is fixed at 8 lanes, so XLEN = 64 is the only supported value.
- `MEMOP_LEN`, 4: width of the memory-op code.
- `REG_ADDRWIDTH`, 5: register index width.

One clock; reset is asynchronous and active-high.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `valid_i`  in  1  operation offered by the pipeline.
- `ready_o`  out  1  LSU can accept; high only in IDLE.
- `mem_op_i`  in  MEMOP_LEN  NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, LWU=6, LD=7, SB=8, SH=9, SW=10, SD=11; values 12–15 are treated as NONE.
- `addr_i`  in  XLEN  effective byte address.
- `wdata_i`  in  XLEN  store data; value sits in the low bits.
- `rd_idx_i`  in  REG_ADDRWIDTH  load destination register.
- `done_o`  out  1  one-cycle completion pulse.
- `rdata_o`  out  XLEN  extended load result; 0 for stores, NONE and misaligned ops.
- `rd_idx_o`  out  REG_ADDRWIDTH  latched `rd_idx_i`.
- `misalign_o`  out  1  qualifies `done_o`: the operation was misaligned.
- `req_valid_o`  out  1  bus request valid.
- `req_ready_i`  in  1  bus accepts the request.
- `req_addr_o`  out  XLEN  `{addr[XLEN-1:3],3'b0}`.
- `req_wen_o`  out  1  1 = store.
- `req_wdata_o`  out  XLEN  store data shifted into its byte lanes.
- `req_wmask_o`  out  8  byte enables (0 for loads).
- `rsp_valid_i`  in  1  bus response or write acknowledge valid.
- `rsp_rdata_i`  in  XLEN  aligned 64-bit read data.
- `rsp_ready_o`  out  1  high only in RSP.

## Operation
- States: IDLE, REQ, RSP, FIN.
- IDLE, on accept (`valid_i & ready_o`):
  - Latch op, address, lane-shifted wdata, wmask and rd_idx.
  - Go to REQ for an aligned load or store.
  - Go to FIN for NONE or a misaligned op; no bus traffic is issued.
- REQ:
  - `req_valid_o`=1, request fields held stable.
  - On `req_ready_i`, go to RSP.
- RSP:
  - `rsp_ready_o`=1.
  - On `rsp_valid_i`, capture the extracted load data and go to FIN.
- FIN:
  - `done_o`=1 for this cycle only; `rdata_o`, `rd_idx_o` and `misalign_o` are valid.
  - Next state is IDLE.
- Alignment rules:
  - H ops require `addr[0]`=0.
  - W ops require `addr[1:0]`=0.
  - D ops require `addr[2:0]`=0.
  - B ops are never misaligned.
- Write path:
  - `req_wdata_o` = `wdata_i << (8*addr[2:0])`.
  - `req_wmask_o` = (B:0x01, H:0x03, W:0x0F, D:0xFF) << `addr[2:0]`.
- Read path:
  - Select the lane `rsp_rdata_i >> (8*addr[2:0])`, then truncate to the access size.
  - LB, LH and LW sign-extend to XLEN; LBU, LHU and LWU zero-extend; LD passes through.
- `rsp_valid_i` outside RSP and `valid_i` outside IDLE are ignored.

## Timing
- Reset values: state = IDLE, `ready_o`=1, all other outputs 0, including `req_valid_o`, `rsp_ready_o`, `done_o`, `rdata_o`, `rd_idx_o`, `misalign_o` and the request fields.
- Latency:
  - Aligned op with zero bus wait: accept at cycle 0, REQ at 1, RSP at 2, `done_o` at 3.
  - Each bus wait cycle adds 1.
  - NONE or misaligned: `done_o` at cycle 1.
- `ready_o` is low from the cycle after accept through FIN; at most one operation is outstanding.
- Back-to-back: the next accept occurs in the IDLE cycle after FIN. Minimum spacing is 4 cycles for bus ops and 2 cycles for NONE or misaligned ops.
- Request fields do not change while `req_valid_o`=1 and `req_ready_i`=0.
- `req_ready_i` and `rsp_valid_i` are only evaluated in their own states. A response arriving in the same cycle the request is accepted is not consumed; it is taken no earlier than the first RSP cycle.
- Asynchronous `rst` in any state forces IDLE and the reset output values immediately. An in-flight bus transaction is abandoned, and the memory side is reset together with the LSU.

## Test plan
- LB, signed byte: `addr`=0x8000_0003, `rsp_rdata`=0x0000_0000_8000_0000 → `req_addr_o`=0x8000_0000, `req_wmask_o`=0; `done_o` at cycle 3 with `rdata_o`=0xFFFF_FFFF_FFFF_FF80. The same case as LBU gives 0x80.
- SW to upper word: `addr`=0x8000_0004, `wdata`=0x1234_5678 → `req_wen_o`=1, `req_wmask_o`=0xF0, `req_wdata_o`=0x1234_5678_0000_0000; `done_o` follows the write ack with `rdata_o`=0.
- Misaligned LD at 0x8000_0002 → no `req_valid_o`; `done_o`=1 and `misalign_o`=1 at cycle 1; `rdata_o`=0.
- Backpressure: `req_ready_i` low for 3 cycles, then `rsp_valid_i` delayed 2 cycles → request fields stable throughout; `done_o` at cycle 8; `ready_o`=0 from cycle 1 to cycle 8.
- Reset in RSP: assert `rst` while waiting → `rsp_ready_o`, `done_o` and `rdata_o` go to 0 at once and `ready_o`=1. After release, a fresh LW of 0x8000_0000 completes normally.
- Back-to-back LD, SD, NONE with `valid_i` held high → accepts at cycles 0, 4 and 8; `done_o` at cycles 3, 7 and 9.
